// File: rtl/wb_stage_dual_pkg.sv
// Shared widths, write-enable encodings and the lane/pair field layout for the
// dual-lane writeback stage.
package wb_stage_dual_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int REG_W       = 32;
   localparam int REG_ADDR_W  = 5;

   localparam logic WRITE_ENABLE  = 1'b1;
   localparam logic WRITE_DISABLE = 1'b0;

   typedef struct packed {
      logic                   v;
      logic [INST_ADDR_W-1:0] pc;
      logic                   we;
      logic [REG_ADDR_W-1:0]  wa;
      logic [REG_W-1:0]       wd;
   } wb_lane_t;

   typedef struct packed {
      wb_lane_t l2;
      wb_lane_t l1;
   } wb_pair_t;

   // Same-destination conflict: only the younger lane may write, lane 2 on a PC tie.
   function automatic logic [1:0] resolve_we(input logic q1,
                                             input logic q2,
                                             input logic same_wa,
                                             input logic lane1_younger);
      logic [1:0] r;
      r = {q2, q1};
      if (q1 && q2 && same_wa) begin
         r = lane1_younger ? 2'b01 : 2'b10;
      end
      return r;
   endfunction

endpackage

// File: rtl/wb_pair_fifo.sv
// DEPTH-entry FIFO of packed instruction pairs with a registered not-full flag.
module wb_pair_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         empty_o,
   output logic         ready_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ready_q, ready_d;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i & ~full & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign rdata_o = mem_q[rd_ptr_q];
   assign ready_o = ready_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
      // Readiness is registered so MEM sees a flag with no combinational path from pop.
      ready_d = (count_d != CNT_W'(DEPTH));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ready_q  <= ready_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/wb_stage_dual.sv
// Dual-lane writeback stage: buffers MEM pairs, resolves same-destination
// conflicts, drops r0 writes and drives single-cycle regfile write strobes.
import wb_stage_dual_pkg::*;

module wb_stage_dual #(
   parameter int ADDR_W = INST_ADDR_W,
   parameter int DATA_W = REG_W,
   parameter int REG_AW = REG_ADDR_W,
   parameter int DEPTH  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              stall_i,
   input  logic              mem_valid_i,
   output logic              wb_ready_o,
   input  logic              mem_v1_i,
   input  logic              mem_v2_i,
   input  logic [ADDR_W-1:0] mem_pc1_i,
   input  logic [ADDR_W-1:0] mem_pc2_i,
   input  logic              mem_we1_i,
   input  logic              mem_we2_i,
   input  logic [REG_AW-1:0] mem_wa1_i,
   input  logic [REG_AW-1:0] mem_wa2_i,
   input  logic [DATA_W-1:0] mem_wd1_i,
   input  logic [DATA_W-1:0] mem_wd2_i,
   output logic [ADDR_W-1:0] pc_o_1,
   output logic [ADDR_W-1:0] pc_o_2,
   output logic              we_o_1,
   output logic              we_o_2,
   output logic [REG_AW-1:0] waddr_o_1,
   output logic [REG_AW-1:0] waddr_o_2,
   output logic [DATA_W-1:0] wdata_o_1,
   output logic [DATA_W-1:0] wdata_o_2,
   output logic [31:0]       retire_cnt_o
);

   typedef struct packed {
      logic              v;
      logic [ADDR_W-1:0] pc;
      logic              we;
      logic [REG_AW-1:0] wa;
      logic [DATA_W-1:0] wd;
   } lane_t;

   localparam int PAIR_W = 2 * $bits(lane_t);

   lane_t             in1, in2, src1, src2;
   logic [PAIR_W-1:0] fifo_rd;
   logic              fifo_ready, fifo_empty;
   logic              push, pop, fifo_push, fifo_pop;
   logic              qual1, qual2;
   logic [1:0]        we_res;

   logic [ADDR_W-1:0] pc1_q, pc1_d, pc2_q, pc2_d;
   logic [REG_AW-1:0] wa1_q, wa1_d, wa2_q, wa2_d;
   logic [DATA_W-1:0] wd1_q, wd1_d, wd2_q, wd2_d;
   logic              we1_q, we1_d, we2_q, we2_d;
   logic [31:0]       retire_q, retire_d;

   assign in1 = {mem_v1_i, mem_pc1_i, mem_we1_i, mem_wa1_i, mem_wd1_i};
   assign in2 = {mem_v2_i, mem_pc2_i, mem_we2_i, mem_wa2_i, mem_wd2_i};

   assign wb_ready_o = fifo_ready & ~flush_i;
   assign push       = mem_valid_i & wb_ready_o;
   assign pop        = ~stall_i & ~flush_i & (~fifo_empty | push);
   // An empty FIFO with a pop in the same cycle forwards the incoming pair directly.
   assign fifo_pop   = pop & ~fifo_empty;
   assign fifo_push  = push & ~(fifo_empty & pop);

   wb_pair_fifo #(
      .W     (PAIR_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush_i (flush_i),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i ({in2, in1}),
      .rdata_o (fifo_rd),
      .empty_o (fifo_empty),
      .ready_o (fifo_ready)
   );

   assign {src2, src1} = fifo_empty ? {in2, in1} : fifo_rd;

   assign qual1  = (src1.we == WRITE_ENABLE) & src1.v & (src1.wa != '0);
   assign qual2  = (src2.we == WRITE_ENABLE) & src2.v & (src2.wa != '0);
   assign we_res = resolve_we(qual1, qual2, src1.wa == src2.wa, src1.pc > src2.pc);

   always_comb begin
      pc1_d    = pc1_q;
      pc2_d    = pc2_q;
      wa1_d    = wa1_q;
      wa2_d    = wa2_q;
      wd1_d    = wd1_q;
      wd2_d    = wd2_q;
      we1_d    = WRITE_DISABLE;
      we2_d    = WRITE_DISABLE;
      retire_d = retire_q;
      if (pop) begin
         pc1_d          = src1.pc;
         pc2_d          = src2.pc;
         wa1_d          = src1.wa;
         wa2_d          = src2.wa;
         wd1_d          = src1.wd;
         wd2_d          = src2.wd;
         {we2_d, we1_d} = we_res;
         retire_d       = retire_q + 32'(src1.v) + 32'(src2.v);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc1_q    <= '0;
         pc2_q    <= '0;
         wa1_q    <= '0;
         wa2_q    <= '0;
         wd1_q    <= '0;
         wd2_q    <= '0;
         we1_q    <= 1'b0;
         we2_q    <= 1'b0;
         retire_q <= '0;
      end else begin
         pc1_q    <= pc1_d;
         pc2_q    <= pc2_d;
         wa1_q    <= wa1_d;
         wa2_q    <= wa2_d;
         wd1_q    <= wd1_d;
         wd2_q    <= wd2_d;
         we1_q    <= we1_d;
         we2_q    <= we2_d;
         retire_q <= retire_d;
      end
   end

   assign pc_o_1       = pc1_q;
   assign pc_o_2       = pc2_q;
   assign we_o_1       = we1_q;
   assign we_o_2       = we2_q;
   assign waddr_o_1    = wa1_q;
   assign waddr_o_2    = wa2_q;
   assign wdata_o_1    = wd1_q;
   assign wdata_o_2    = wd2_q;
   assign retire_cnt_o = retire_q;

endmodule

// File: tb/tb_wb_stage_dual.sv
// Scoreboard bench for wb_stage_dual: a queue-based pair model predicts each
// cycle's regfile strobes; a negedge monitor compares them against the DUT.
module tb_wb_stage_dual;

   localparam int DEPTH = 2;

   typedef struct packed {
      logic        v1;
      logic [31:0] pc1;
      logic        we1;
      logic [4:0]  wa1;
      logic [31:0] wd1;
      logic        v2;
      logic [31:0] pc2;
      logic        we2;
      logic [4:0]  wa2;
      logic [31:0] wd2;
   } pair_t;

   typedef struct packed {
      logic        we1;
      logic        we2;
      logic [31:0] pc1;
      logic [31:0] pc2;
      logic [4:0]  wa1;
      logic [4:0]  wa2;
      logic [31:0] wd1;
      logic [31:0] wd2;
      logic [31:0] ret;
   } rec_t;

   logic        clk, rst;
   logic        flush_i, stall_i, mem_valid_i, wb_ready_o;
   logic        mem_v1_i, mem_v2_i, mem_we1_i, mem_we2_i;
   logic [31:0] mem_pc1_i, mem_pc2_i, mem_wd1_i, mem_wd2_i;
   logic [4:0]  mem_wa1_i, mem_wa2_i;
   logic [31:0] pc_o_1, pc_o_2, wdata_o_1, wdata_o_2, retire_cnt_o;
   logic        we_o_1, we_o_2;
   logic [4:0]  waddr_o_1, waddr_o_2;

   rec_t  sb[$];
   pair_t mq[$];
   logic  m_ready;
   rec_t  m_out;
   int    checks   = 0;
   int    failures = 0;

   wb_stage_dual dut (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush_i),
      .stall_i      (stall_i),
      .mem_valid_i  (mem_valid_i),
      .wb_ready_o   (wb_ready_o),
      .mem_v1_i     (mem_v1_i),
      .mem_v2_i     (mem_v2_i),
      .mem_pc1_i    (mem_pc1_i),
      .mem_pc2_i    (mem_pc2_i),
      .mem_we1_i    (mem_we1_i),
      .mem_we2_i    (mem_we2_i),
      .mem_wa1_i    (mem_wa1_i),
      .mem_wa2_i    (mem_wa2_i),
      .mem_wd1_i    (mem_wd1_i),
      .mem_wd2_i    (mem_wd2_i),
      .pc_o_1       (pc_o_1),
      .pc_o_2       (pc_o_2),
      .we_o_1       (we_o_1),
      .we_o_2       (we_o_2),
      .waddr_o_1    (waddr_o_1),
      .waddr_o_2    (waddr_o_2),
      .wdata_o_1    (wdata_o_1),
      .wdata_o_2    (wdata_o_2),
      .retire_cnt_o (retire_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic rec_t actual_outputs();
      rec_t a;
      a.we1 = we_o_1;
      a.we2 = we_o_2;
      a.pc1 = pc_o_1;
      a.pc2 = pc_o_2;
      a.wa1 = waddr_o_1;
      a.wa2 = waddr_o_2;
      a.wd1 = wdata_o_1;
      a.wd2 = wdata_o_2;
      a.ret = retire_cnt_o;
      return a;
   endfunction

   // Monitor: every cycle after reset has exactly one predicted record.
   always @(negedge clk) begin
      rec_t e;
      rec_t a;
      if (rst && sb.size() > 0) begin
         e = sb.pop_front();
         a = actual_outputs();
         checks++;
         if (a !== e) begin
            failures++;
            $display("FAIL wb_outputs t=%0t got=%h expected=%h", $time, a, e);
         end
      end
   end

   // Reference: a popped pair writes every qualified lane, except that on a
   // same-register clash only the younger instruction (higher PC, lane 2 on tie) writes.
   function automatic rec_t pop_result(input pair_t p, input rec_t prev);
      rec_t r;
      bit   w1, w2;
      w1 = p.v1 && p.we1 && (p.wa1 != 5'd0);
      w2 = p.v2 && p.we2 && (p.wa2 != 5'd0);
      if (w1 && w2 && p.wa1 == p.wa2) begin
         if (p.pc2 >= p.pc1) w1 = 1'b0;
         else                w2 = 1'b0;
      end
      r.we1 = w1;
      r.we2 = w2;
      r.pc1 = p.pc1;
      r.pc2 = p.pc2;
      r.wa1 = p.wa1;
      r.wa2 = p.wa2;
      r.wd1 = p.wd1;
      r.wd2 = p.wd2;
      r.ret = prev.ret + 32'(p.v1) + 32'(p.v2);
      return r;
   endfunction

   function automatic pair_t rand_pair();
      pair_t p;
      p.v1  = ($urandom_range(0, 7) != 0);
      p.v2  = ($urandom_range(0, 7) != 0);
      p.we1 = ($urandom_range(0, 5) != 0);
      p.we2 = ($urandom_range(0, 5) != 0);
      p.wa1 = 5'($urandom_range(0, 3));
      p.wa2 = 5'($urandom_range(0, 3));
      p.pc1 = 32'h1c00_0000 + 32'(4 * $urandom_range(0, 3));
      p.pc2 = 32'h1c00_0000 + 32'(4 * $urandom_range(0, 3));
      p.wd1 = $urandom;
      p.wd2 = $urandom;
      return p;
   endfunction

   function automatic pair_t mk_pair(input bit v1, input logic [31:0] pc1, input bit we1,
                                     input logic [4:0] wa1, input logic [31:0] wd1,
                                     input bit v2, input logic [31:0] pc2, input bit we2,
                                     input logic [4:0] wa2, input logic [31:0] wd2);
      pair_t p;
      p.v1 = v1; p.pc1 = pc1; p.we1 = we1; p.wa1 = wa1; p.wd1 = wd1;
      p.v2 = v2; p.pc2 = pc2; p.we2 = we2; p.wa2 = wa2; p.wd2 = wd2;
      return p;
   endfunction

   task automatic step(input logic val, input logic fl, input logic st, input pair_t p);
      logic push;
      @(negedge clk);
      #1;
      mem_valid_i = val;
      flush_i     = fl;
      stall_i     = st;
      mem_v1_i    = p.v1;  mem_pc1_i = p.pc1; mem_we1_i = p.we1;
      mem_wa1_i   = p.wa1; mem_wd1_i = p.wd1;
      mem_v2_i    = p.v2;  mem_pc2_i = p.pc2; mem_we2_i = p.we2;
      mem_wa2_i   = p.wa2; mem_wd2_i = p.wd2;
      #1;
      checks++;
      if (wb_ready_o !== (m_ready & ~fl)) begin
         failures++;
         $display("FAIL wb_ready t=%0t got=%b expected=%b", $time, wb_ready_o, m_ready & ~fl);
      end
      push = val & m_ready & ~fl;
      m_out.we1 = 1'b0;
      m_out.we2 = 1'b0;
      if (fl) begin
         mq.delete();
      end else begin
         if (push) mq.push_back(p);
         if (!st && mq.size() > 0) m_out = pop_result(mq.pop_front(), m_out);
      end
      m_ready = (mq.size() < DEPTH);
      sb.push_back(m_out);
   endtask

   task automatic check_reset_state(input string tag);
      rec_t a;
      a = actual_outputs();
      checks++;
      if (a !== '0 || wb_ready_o !== 1'b0) begin
         failures++;
         $display("FAIL %s got=%h ready=%b expected=all zero", tag, a, wb_ready_o);
      end
   endtask

   // Asserted between edges so the clear is seen to be asynchronous.
   task automatic apply_reset(input string tag);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_reset_state(tag);
      mq.delete();
      m_out = '0;
      repeat (2) @(negedge clk);
      #1;
      rst = 1'b1;
      // The next step is driven after at least one edge out of reset.
      m_ready = 1'b1;
   endtask

   initial begin
      pair_t idle;
      idle        = '0;
      rst         = 1'b0;
      flush_i     = 1'b0;
      stall_i     = 1'b0;
      mem_valid_i = 1'b0;
      mem_v1_i = 0; mem_pc1_i = 0; mem_we1_i = 0; mem_wa1_i = 0; mem_wd1_i = 0;
      mem_v2_i = 0; mem_pc2_i = 0; mem_we2_i = 0; mem_wa2_i = 0; mem_wd2_i = 0;
      m_out   = '0;
      m_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check_reset_state("reset_initial");
      rst     = 1'b1;
      m_ready = 1'b1;

      // single pair, both lanes write
      step(1, 0, 0, mk_pair(1, 32'h1c00_0000, 1, 5'd3, 32'h11, 1, 32'h1c00_0004, 1, 5'd4, 32'h22));
      step(0, 0, 0, idle);
      // conflict on r5: older/younger by PC, then swapped, then equal PCs
      step(1, 0, 0, mk_pair(1, 32'h1c00_0008, 1, 5'd5, 32'haaaa, 1, 32'h1c00_0004, 1, 5'd5, 32'hbbbb));
      step(1, 0, 0, mk_pair(1, 32'h1c00_0004, 1, 5'd5, 32'hcccc, 1, 32'h1c00_0008, 1, 5'd5, 32'hdddd));
      step(1, 0, 0, mk_pair(1, 32'h1c00_0010, 1, 5'd5, 32'heeee, 1, 32'h1c00_0010, 1, 5'd5, 32'hffff));
      // r0 write plus invalid lane 2, then an all-invalid pair
      step(1, 0, 0, mk_pair(1, 32'h1c00_0020, 1, 5'd0, 32'h1234, 0, 32'h1c00_0024, 1, 5'd7, 32'h5678));
      step(1, 0, 0, mk_pair(0, 32'h1c00_0030, 1, 5'd1, 32'h1, 0, 32'h1c00_0034, 1, 5'd2, 32'h2));
      step(0, 0, 0, idle);
      // backpressure: four stalled pushes, only two fit
      repeat (4) step(1, 0, 1, rand_pair());
      repeat (3) step(0, 0, 0, idle);
      // flush with a full FIFO and a simultaneous push
      repeat (2) step(1, 0, 1, rand_pair());
      step(1, 1, 0, rand_pair());
      repeat (2) step(0, 0, 0, idle);
      // reset while traffic is buffered
      step(1, 0, 0, rand_pair());
      repeat (2) step(1, 0, 1, rand_pair());
      apply_reset("reset_mid_traffic");
      step(0, 0, 0, idle);

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
              ($urandom_range(0, 3) == 0), rand_pair());
      end
      repeat (3) step(0, 0, 0, idle);

      @(negedge clk);
      #2;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
